rr_sel_arbiter: RTL and testbench
=================================

RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum grant length in cycles; 0 disables the timeout.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  4  per-channel request; bit0=a, bit1=b, bit2=c, bit3=d of the downstream 4:1 mux.
REQ-005 done  input  1  one-cycle pulse from the granted consumer that ends the current grant.
REQ-006 s0  output  1  mux select LSB, registered.
REQ-007 s1  output  1  mux select MSB, registered.
REQ-008 gnt  output  4  one-hot grant, registered; all zero when no grant is active.
REQ-009 busy  output  1  high while in GRANT state, registered.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-011 In IDLE with req!=0, the block SHALL select the first requesting channel at or after ptr, wrapping 3->0, and enter GRANT on the next edge.
REQ-012 On entry to GRANT, the block SHALL set {s1,s0} to the winner index, gnt to the winner one-hot, busy=1, and hold_cnt=1 in the same edge.
REQ-013 Grant latency SHALL be exactly 1 cycle from the first edge sampling req!=0 in IDLE.
REQ-014 In GRANT, hold_cnt SHALL increment each cycle and saturate at MAX_HOLD; its width SHALL be clog2(MAX_HOLD+1), minimum 1 bit.
REQ-015 GRANT SHALL exit to IDLE on the edge where done=1, or req[winner]=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD).
REQ-016 On exit, the block SHALL clear gnt to 0 and busy to 0, and set ptr=(winner+1) mod 4.
REQ-017 On exit, s0/s1 SHALL hold the last winner index so the mux select stays stable while idle.
REQ-018 After every grant, the block SHALL spend at least one IDLE cycle, giving a 1-cycle gap with gnt=0.
REQ-019 Simultaneous exit conditions SHALL produce a single exit with identical behaviour to any one of them.
REQ-020 done while in IDLE SHALL be ignored.
REQ-021 Requests from non-granted channels during GRANT SHALL NOT affect gnt, s0, s1 or ptr.
REQ-022 With MAX_HOLD=0, a grant SHALL persist indefinitely until done or request drop.
REQ-023 gnt SHALL never have more than one bit set.
REQ-024 When busy=1, gnt SHALL equal the one-hot of {s1,s0}.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force state=IDLE, s0=0, s1=0, gnt=0, busy=0, ptr=0, and hold_cnt=0.
REQ-026 Reset asserted mid-grant SHALL abort the grant immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, the first arbitration SHALL favour channel 0.

Verification
REQ-028 Reset, then req=4'b1111 held with done pulsed each grant: grants SHALL go 0,1,2,3,0 with {s1,s0}=00,01,10,11,00, separated by one gnt=0 cycle.
REQ-029 ptr=2 and req=4'b0011: the block SHALL grant channel 0 (wrap-around), gnt=0001, {s1,s0}=00.
REQ-030 MAX_HOLD=8, req=4'b0100 held, no done: gnt=0100 SHALL stay high exactly 8 cycles, drop for 1 cycle, then re-grant channel 2.
REQ-031 Grant on channel 1, then req[1] drops: gnt SHALL clear on the next edge, s0=1/s1=0 SHALL be retained, and ptr SHALL be 2.
REQ-032 rst_n pulsed low mid-grant on channel 3: gnt, busy, s0 and s1 SHALL go to 0 without a clock edge, and the next grant with req=4'b1000 SHALL be channel 3 one cycle after release.
REQ-033 done and req drop in the same cycle: exactly one exit SHALL occur and ptr SHALL advance by one.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Four-channel round-robin arbiter driving the select lines of a downstream 4:1 mux.
// A grant lasts until done, a drop of the winner's request, or the optional hold timeout.
module rr_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt,
    output logic       busy
);

    localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    // With the timeout disabled the counter simply parks at its top value.
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HOLD_MAX;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic            win_found;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    logic            exit_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        win_found  = 1'b0;
        win_idx    = ptr_q;
        cand       = 2'd0;

        // Scan starting at ptr; the 2-bit add wraps 3 -> 0 for free.
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        exit_grant = done || !req[sel_q] || ((MAX_HOLD != 0) && (hold_q == HOLD_MAX));

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    sel_d   = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    busy_d  = 1'b1;
                    hold_d  = HW'(1);
                end
            end
            GRANT: begin
                // sel is left untouched on exit so the mux stays on the last winner.
                if (exit_grant) begin
                    state_d = IDLE;
                    gnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    hold_d  = '0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s0   = sel_q[0];
    assign s1   = sel_q[1];
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: rotation, wrap-around, hold timeout,
// request drop, simultaneous exits and asynchronous reset mid-grant.
module tb_rr_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       s0;
  logic       s1;
  logic [3:0] gnt;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  rr_sel_arbiter #(.MAX_HOLD(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .done (done),
    .s0   (s0),
    .s1   (s1),
    .gnt  (gnt),
    .busy (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // observed vector is {busy, s1, s0, gnt}
  function automatic logic [6:0] e(input logic b, input logic [1:0] sel, input logic [3:0] g);
    return {b, sel, g};
  endfunction

  task automatic check(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    obs = {busy, s1, s0, gnt};
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed {busy,s1,s0,gnt}=%b expected=%b", tag, obs, expv);
    end
  endtask

  // advance one clock, land 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_async", e(0, 2'd0, 4'b0000));
    step();
    step();
    rst_n = 1'b1;
    step();
    check("reset_idle", e(0, 2'd0, 4'b0000));

    // full rotation with all channels requesting and done every grant
    req = 4'b1111;
    step(); check("rot_g0", e(1, 2'd0, 4'b0001));
    done = 1'b1;
    step(); check("rot_gap0", e(0, 2'd0, 4'b0000));
    done = 1'b0;
    step(); check("rot_g1", e(1, 2'd1, 4'b0010));
    done = 1'b1;
    step(); check("rot_gap1", e(0, 2'd1, 4'b0000));
    done = 1'b0;
    step(); check("rot_g2", e(1, 2'd2, 4'b0100));
    done = 1'b1;
    step(); check("rot_gap2", e(0, 2'd2, 4'b0000));
    done = 1'b0;
    step(); check("rot_g3", e(1, 2'd3, 4'b1000));
    done = 1'b1;
    step(); check("rot_gap3", e(0, 2'd3, 4'b0000));
    done = 1'b0;
    step(); check("rot_g0_again", e(1, 2'd0, 4'b0001));
    done = 1'b1;
    req  = 4'b0000;
    step(); check("rot_end", e(0, 2'd0, 4'b0000));
    done = 1'b0;

    // ptr is 1: grant channel 1, then drop its request
    req = 4'b0010;
    step(); check("drop_grant1", e(1, 2'd1, 4'b0010));
    req = 4'b0000;
    step(); check("drop_exit_sel_kept", e(0, 2'd1, 4'b0000));
    step(); check("drop_stay_idle", e(0, 2'd1, 4'b0000));

    // ptr is now 2: channels 2,3 idle so the scan wraps to channel 0
    req = 4'b0011;
    step(); check("wrap_grant0", e(1, 2'd0, 4'b0001));

    // done and request drop together: one exit, ptr 0 -> 1
    done = 1'b1;
    req  = 4'b0000;
    step(); check("dual_exit", e(0, 2'd0, 4'b0000));
    done = 1'b0;
    req  = 4'b1111;
    step(); check("dual_next_ch1", e(1, 2'd1, 4'b0010));
    req = 4'b1101;
    #3 req = 4'b1111;
    step(); check("others_no_effect_a", e(1, 2'd1, 4'b0010));
    req = 4'b1010;
    step(); check("others_no_effect_b", e(1, 2'd1, 4'b0010));
    done = 1'b1;
    req  = 4'b0000;
    step(); check("ch1_exit", e(0, 2'd1, 4'b0000));

    // ptr is 2; done in IDLE together with a request must not block the grant
    req  = 4'b0100;
    done = 1'b1;
    step(); check("hold_first", e(1, 2'd2, 4'b0100));
    done = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      step(); check($sformatf("hold_cycle%0d", k), e(1, 2'd2, 4'b0100));
    end
    step(); check("hold_timeout_gap", e(0, 2'd2, 4'b0000));
    step(); check("hold_regrant", e(1, 2'd2, 4'b0100));

    // ptr becomes 3 after the drop; grant channel 3 then reset mid-grant
    req = 4'b0000;
    step(); check("pre_rst_exit", e(0, 2'd2, 4'b0000));
    req = 4'b1000;
    step(); check("rst_grant3", e(1, 2'd3, 4'b1000));
    #2 rst_n = 1'b0;
    #1 check("rst_mid_grant_async", e(0, 2'd0, 4'b0000));
    step();
    rst_n = 1'b1;
    check("rst_released", e(0, 2'd0, 4'b0000));
    step(); check("rst_next_grant3", e(1, 2'd3, 4'b1000));

    // ptr reset to 0 so the first arbitration after reset favours channel 0
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    rst_n = 1'b1;
    step(); check("post_rst_favour0", e(1, 2'd0, 4'b0001));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
